// File: rtl/pe_mac_acc.sv
// pe_mac_acc: Q8.8 MAC processing element producing a saturating K_LEN-term dot product.
// Optional macro PE_MAC_SAT_FLAG_EN adds the sticky sat_flag output. Rev 1.0
`default_nettype none

module pe_mac_acc #(
  parameter int K_LEN = 16,
  parameter int CNT_W = $clog2(K_LEN + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a_in,
  input  logic [15:0] w_in,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef PE_MAC_SAT_FLAG_EN
  output logic        sat_flag,
`endif
  output logic [15:0] acc_out
);

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [15:0]        p_q, p_d;
  logic               p_vld_q, p_vld_d;
  logic [15:0]        acc_q, acc_d;

  logic               accept;
  logic signed [31:0] a_ext, w_ext, prod32;
  logic signed [32:0] prod_rnd, prod_shr;
  logic [15:0]        p_sat;
  logic               p_ovf;
  logic signed [16:0] s17;
  logic [15:0]        acc_sat;
  logic               acc_ovf;

  // Stage 1: Q16.16 product, half-up rounding back to Q8.8, then clamp.
  always_comb begin
    a_ext    = {{16{a_in[15]}}, a_in};
    w_ext    = {{16{w_in[15]}}, w_in};
    prod32   = a_ext * w_ext;
    prod_rnd = {prod32[31], prod32} + 33'sd128;
    prod_shr = prod_rnd >>> 8;
    p_ovf    = 1'b1;
    if (prod_shr > 33'sd32767) begin
      p_sat = 16'h7FFF;
    end else if (prod_shr < -33'sd32768) begin
      p_sat = 16'h8000;
    end else begin
      p_sat = prod_shr[15:0];
      p_ovf = 1'b0;
    end
  end

  // Stage 2: a 17-bit sum overflowed exactly when its top two bits disagree.
  always_comb begin
    s17     = $signed({acc_q[15], acc_q}) + $signed({p_q[15], p_q});
    acc_ovf = s17[16] ^ s17[15];
    if (acc_ovf) begin
      acc_sat = s17[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      acc_sat = s17[15:0];
    end
  end

  assign accept = in_valid && (state_q == ST_ACC);

`ifdef PE_MAC_SAT_FLAG_EN
  logic sat_q, sat_d;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    p_d     = p_q;
    p_vld_d = 1'b0;
    acc_d   = acc_q;
`ifdef PE_MAC_SAT_FLAG_EN
    sat_d   = sat_q;
    if ((accept && p_ovf) || (p_vld_q && acc_ovf)) begin
      sat_d = 1'b1;
    end
`endif
    if (accept) begin
      p_d     = p_sat;
      p_vld_d = 1'b1;
      count_d = count_q + CNT_W'(1);
    end
    if (p_vld_q) begin
      acc_d = acc_sat;
    end
    unique case (state_q)
      ST_ACC: begin
        if (accept && (count_q == CNT_W'(K_LEN - 1))) begin
          state_d = ST_DRAIN;
        end
      end
      // Hold until the final product has been folded into acc.
      ST_DRAIN: begin
        if (!p_vld_q) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_ACC;
          acc_d   = '0;
          count_d = '0;
`ifdef PE_MAC_SAT_FLAG_EN
          sat_d   = 1'b0;
`endif
        end
      end
      default: state_d = ST_ACC;
    endcase
    if (clear) begin
      state_d = ST_ACC;
      count_d = '0;
      p_vld_d = 1'b0;
      acc_d   = '0;
`ifdef PE_MAC_SAT_FLAG_EN
      sat_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      count_q <= '0;
      p_q     <= '0;
      p_vld_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      p_q     <= p_d;
      p_vld_q <= p_vld_d;
      acc_q   <= acc_d;
    end
  end

`ifdef PE_MAC_SAT_FLAG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end
  assign sat_flag = sat_q;
`endif

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_OUT);
  assign acc_out   = acc_q;

endmodule

`default_nettype wire
